bus_transfer_ctrl: RTL and testbench
====================================

Name: bus_transfer_ctrl

Overview:
- Sequencer that owns the shared 8-bit register bus of the model computer.
- Drives the per-register read_enable / write_enable strobes that the register file consumes.
- Executes one command at a time: register-to-register move, immediate load, or readback to the requester.
- Guarantees at most one bus driver per cycle, plus one idle turnaround cycle between transfers.

Parameters:
- NREG, 8: number of registers on the bus (index width IW = clog2(NREG)).
- DW, 8: bus data width.
- SETTLE, 1: cycles a source drives the bus before capture (1..15).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- res  in  1  reset, synchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  0=MOV, 1=LDI, 2=RD, 3=NOP.
- cmd_src  in  IW  source register index (MOV, RD).
- cmd_dst  in  IW  destination register index (MOV, LDI).
- cmd_imm  in  DW  immediate value (LDI).
- reg_read_en  out  NREG  one-hot; drives the selected register onto the bus.
- reg_write_en  out  NREG  one-hot; the selected register captures the bus.
- bus_out  out  DW  controller drive value (LDI).
- bus_out_en  out  1  controller drives the bus; the top level builds the tri-state.
- bus_in  in  DW  resolved bus value.
- rsp_valid  out  1  one-cycle pulse, RD data available.
- rsp_data  out  DW  RD result; held until the next RD completes.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when a command is rejected.

Behaviour:
- All outputs are registered. Reset values: cmd_ready=1, reg_read_en=0, reg_write_en=0, bus_out=0, bus_out_en=0, rsp_valid=0, rsp_data=0, busy=0, err=0. State=IDLE, settle counter=0.
- Accept: cmd_valid && cmd_ready at an edge. Latch op, src, dst and imm; cmd_ready drops on the following cycle.
- States and transitions:
  - IDLE -> DRIVE on accept of MOV/LDI/RD.
  - DRIVE -> SETTLE counter reaches SETTLE-1 -> XFER.
  - XFER -> TURN.
  - TURN -> IDLE.
- DRIVE:
  - MOV and RD assert reg_read_en[src].
  - LDI asserts bus_out_en with bus_out=imm.
  - Held for SETTLE cycles.
- XFER (exactly 1 cycle):
  - The source enable from DRIVE is still held.
  - MOV/LDI: reg_write_en[dst]=1; the register latches at the end of XFER.
  - RD: rsp_data <= bus_in at the end of XFER; rsp_valid is high in the TURN cycle.
- TURN: all enables 0 (bus released). No write or read strobe may be active in TURN.
- Latency with SETTLE=1:
  - Accept edge -> DRIVE cycle 1 -> XFER cycle 2 -> TURN cycle 3 -> cmd_ready=1 in cycle 4.
  - Throughput is one command per SETTLE+3 cycles.
- NOP: accepted, no state change, no strobes, cmd_ready stays 1.
- Rejection: src >= NREG (MOV/RD) or dst >= NREG (MOV/LDI).
  - The command is consumed and err pulses in the next cycle.
  - No enables are asserted; the controller remains in IDLE.
- MOV with src==dst is legal: both read_en and write_en are set for the same index, and the register reloads its own value.
- Invariants, checked by assertions:
  - popcount(reg_read_en) + bus_out_en <= 1 in every cycle.
  - popcount(reg_write_en) <= 1.
  - reg_write_en is never high unless a source is driving.
- Reset mid-operation: at the edge where res=1 is sampled, all enables drop and the state returns to IDLE. The pending command is discarded and no rsp_valid or err is produced. A write already completed remains in the register.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- Shared package bus_pkg holds:
  - op encodings OP_MOV/OP_LDI/OP_RD/OP_NOP.
  - state enum IDLE/DRIVE/XFER/TURN.
  - DW and NREG defaults.
- One sub-module, bus_sel_decode: index plus enable -> one-hot NREG vector, with an out-of-range flag. It is instantiated once each for read and for write selection.

Test Plan:
- Reset, then MOV src=2 dst=5 with reg2 model=0xA5:
  - read_en=0x04 in cycles 1-2.
  - write_en=0x20 in cycle 2 only.
  - reg5 model=0xA5.
  - cmd_ready=1 in cycle 4.
- LDI dst=7 imm=0x3C:
  - bus_out_en=1 and bus_out=0x3C in cycles 1-2.
  - write_en=0x80 in cycle 2.
  - reg_read_en=0 throughout.
- RD src=0 with reg0=0x5A:
  - rsp_valid pulses in cycle 3 with rsp_data=0x5A.
  - rsp_data holds 0x5A after the pulse.
- Back-to-back MOV commands with cmd_valid held high:
  - Second accept occurs exactly 4 cycles after the first.
  - TURN cycle between them has all enables 0.
  - The one-driver invariant holds throughout.
- With NREG=6, MOV dst=6:
  - err pulses for 1 cycle.
  - No strobes asserted; controller stays ready.
- Assert res during the XFER of a MOV:
  - All enables are 0 from the next cycle and busy=0.
  - No rsp_valid or err is produced.
  - A following LDI executes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the register-bus transfer controller: command
// opcodes, sequencer states and default bus geometry.
package bus_pkg;

    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 8;

    typedef enum logic [1:0] {
        OP_MOV = 2'd0,
        OP_LDI = 2'd1,
        OP_RD  = 2'd2,
        OP_NOP = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        XFER  = 2'd2,
        TURN  = 2'd3
    } state_t;

    // Register index width; a single-register bus still needs one index bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// Command handshake, register strobes and bus data of the transfer
// controller. The requester / register file side uses the master modport,
// the controller uses the slave modport.
interface bus_transfer_ctrl_if #(
    parameter int NREG = bus_pkg::NREG_DEF,
    parameter int DW   = bus_pkg::DW_DEF
);
    import bus_pkg::*;

    localparam int IW = idx_width(NREG);

    logic            cmd_valid;
    logic            cmd_ready;
    op_t             cmd_op;
    logic [IW-1:0]   cmd_src;
    logic [IW-1:0]   cmd_dst;
    logic [DW-1:0]   cmd_imm;
    logic [NREG-1:0] reg_read_en;
    logic [NREG-1:0] reg_write_en;
    logic [DW-1:0]   bus_out;
    logic            bus_out_en;
    logic [DW-1:0]   bus_in;
    logic            rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            busy;
    logic            err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_in,
        input  cmd_ready, reg_read_en, reg_write_en, bus_out, bus_out_en,
               rsp_valid, rsp_data, busy, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_imm, bus_in,
        output cmd_ready, reg_read_en, reg_write_en, bus_out, bus_out_en,
               rsp_valid, rsp_data, busy, err
    );

endinterface

// File: rtl/bus_sel_decode.sv
// Register index to one-hot select, with a flag for indices beyond the
// populated registers. A disabled or out-of-range index selects nothing.
module bus_sel_decode #(
    parameter int NREG = 8,
    parameter int IW   = 3
) (
    input  logic [IW-1:0]   i_idx,
    input  logic            i_en,
    output logic [NREG-1:0] o_sel,
    output logic            o_oor
);

    logic [31:0] w_idx_ext;

    assign w_idx_ext = 32'(i_idx);
    assign o_oor     = i_en && (w_idx_ext >= 32'(NREG));

    // One-hot expansion; an index past NREG simply matches no bit.
    always_comb begin
        o_sel = '0;
        for (int i = 0; i < NREG; i++) begin
            o_sel[i] = i_en && (w_idx_ext == 32'(i));
        end
    end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Register bus sequencer: runs one MOV / LDI / RD at a time with a single
// bus driver per cycle and a released-bus turnaround cycle between transfers.
//
//   state | meaning
//   IDLE  | ready for a command, bus released
//   DRIVE | source (register or controller) drives the bus for SETTLE cycles
//   XFER  | source still driving, destination strobe or readback capture
//   TURN  | all enables low, bus turnaround; RD response pulse
module bus_transfer_ctrl
    import bus_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int DW     = DW_DEF,
    parameter int SETTLE = 1
) (
    input logic               clk,
    input logic               res,
    bus_transfer_ctrl_if.slave io_bus
);

    localparam int         IW          = idx_width(NREG);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t          r_state;
    op_t             r_op;
    logic [3:0]      r_settle_cnt;
    logic [NREG-1:0] r_wr_sel;
    logic            r_cmd_ready;
    logic [NREG-1:0] r_reg_read_en;
    logic [NREG-1:0] r_reg_write_en;
    logic [DW-1:0]   r_bus_out;
    logic            r_bus_out_en;
    logic            r_rsp_valid;
    logic [DW-1:0]   r_rsp_data;
    logic            r_busy;
    logic            r_err;

    logic            w_rd_need;
    logic            w_wr_need;
    logic [NREG-1:0] w_rd_sel;
    logic [NREG-1:0] w_wr_sel;
    logic            w_rd_oor;
    logic            w_wr_oor;
    logic            w_accept;

    assign w_rd_need = (io_bus.cmd_op == OP_MOV) || (io_bus.cmd_op == OP_RD);
    assign w_wr_need = (io_bus.cmd_op == OP_MOV) || (io_bus.cmd_op == OP_LDI);
    assign w_accept  = io_bus.cmd_valid && r_cmd_ready;

    bus_sel_decode #(.NREG(NREG), .IW(IW)) u_rd_decode (
        .i_idx (io_bus.cmd_src),
        .i_en  (w_rd_need),
        .o_sel (w_rd_sel),
        .o_oor (w_rd_oor)
    );

    bus_sel_decode #(.NREG(NREG), .IW(IW)) u_wr_decode (
        .i_idx (io_bus.cmd_dst),
        .i_en  (w_wr_need),
        .o_sel (w_wr_sel),
        .o_oor (w_wr_oor)
    );

    // Sequencer with all outputs registered; decoded selects are captured at
    // accept so the command inputs are free to change while busy.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state        <= IDLE;
            r_op           <= OP_NOP;
            r_settle_cnt   <= '0;
            r_wr_sel       <= '0;
            r_cmd_ready    <= 1'b1;
            r_reg_read_en  <= '0;
            r_reg_write_en <= '0;
            r_bus_out      <= '0;
            r_bus_out_en   <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_busy         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_err       <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_rd_oor || w_wr_oor) begin
                            r_err <= 1'b1;
                        end else if (io_bus.cmd_op != OP_NOP) begin
                            r_state       <= DRIVE;
                            r_op          <= io_bus.cmd_op;
                            r_settle_cnt  <= '0;
                            r_wr_sel      <= w_wr_sel;
                            r_reg_read_en <= w_rd_sel;
                            r_bus_out_en  <= (io_bus.cmd_op == OP_LDI);
                            r_bus_out     <= (io_bus.cmd_op == OP_LDI) ? io_bus.cmd_imm : '0;
                            r_cmd_ready   <= 1'b0;
                            r_busy        <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state        <= XFER;
                        r_reg_write_en <= r_wr_sel;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                XFER: begin
                    r_state        <= TURN;
                    r_reg_read_en  <= '0;
                    r_reg_write_en <= '0;
                    r_bus_out_en   <= 1'b0;
                    r_bus_out      <= '0;
                    if (r_op == OP_RD) begin
                        r_rsp_data  <= io_bus.bus_in;
                        r_rsp_valid <= 1'b1;
                    end
                end
                TURN: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_bus.cmd_ready    = r_cmd_ready;
    assign io_bus.reg_read_en  = r_reg_read_en;
    assign io_bus.reg_write_en = r_reg_write_en;
    assign io_bus.bus_out      = r_bus_out;
    assign io_bus.bus_out_en   = r_bus_out_en;
    assign io_bus.rsp_valid    = r_rsp_valid;
    assign io_bus.rsp_data     = r_rsp_data;
    assign io_bus.busy         = r_busy;
    assign io_bus.err          = r_err;

    a_one_driver: assert property (@(posedge clk)
        ($countones(r_reg_read_en) + (r_bus_out_en ? 1 : 0)) <= 1);
    a_one_writer: assert property (@(posedge clk)
        $countones(r_reg_write_en) <= 1);
    a_write_has_src: assert property (@(posedge clk)
        (r_reg_write_en != '0) |-> ((r_reg_read_en != '0) || r_bus_out_en));

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Bench for bus_transfer_ctrl: an 8-register instance (SETTLE=1) and a
// 6-register instance (SETTLE=3) share the clock and reset. The bench acts
// as the register file and keeps a command-level model of register contents.
module tb_bus_transfer_ctrl;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic res;
    logic tb_load;

    always #5 clk = ~clk;

    bus_transfer_ctrl_if #(.NREG(8), .DW(8)) if8 ();
    bus_transfer_ctrl_if #(.NREG(6), .DW(8)) if6 ();

    bus_transfer_ctrl #(.NREG(8), .DW(8), .SETTLE(1)) dut8 (
        .clk    (clk),
        .res    (res),
        .io_bus (if8)
    );

    bus_transfer_ctrl #(.NREG(6), .DW(8), .SETTLE(3)) dut6 (
        .clk    (clk),
        .res    (res),
        .io_bus (if6)
    );

    logic [7:0] env8 [8];
    logic [7:0] env6 [6];
    logic [7:0] init_val [2][8];
    logic [7:0] mdl [2][8];
    logic [7:0] exp_rsp [2];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    int         acc_last [2];
    int         acc_prev [2];

    // Register files: preload during reset, then capture the bus on a strobe.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (tb_load) env8[i] <= init_val[0][i];
            else if (if8.reg_write_en[i]) env8[i] <= if8.bus_in;
        end
        for (int i = 0; i < 6; i++) begin
            if (tb_load) env6[i] <= init_val[1][i];
            else if (if6.reg_write_en[i]) env6[i] <= if6.bus_in;
        end
    end

    // Resolved bus: OR of every enabled driver.
    always_comb begin
        logic [7:0] v8;
        logic [7:0] v6;
        v8 = if8.bus_out_en ? if8.bus_out : 8'h00;
        v6 = if6.bus_out_en ? if6.bus_out : 8'h00;
        for (int i = 0; i < 8; i++) if (if8.reg_read_en[i]) v8 = v8 | env8[i];
        for (int i = 0; i < 6; i++) if (if6.reg_read_en[i]) v6 = v6 | env6[i];
        if8.bus_in = v8;
        if6.bus_in = v6;
    end

    // Cycle stamps of command accepts per instance.
    always_ff @(posedge clk) begin
        cyc <= cyc + 1;
        if (if8.cmd_valid && if8.cmd_ready) begin
            acc_prev[0] <= acc_last[0];
            acc_last[0] <= cyc;
        end
        if (if6.cmd_valid && if6.cmd_ready) begin
            acc_prev[1] <= acc_last[1];
            acc_last[1] <= cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] obs_status(input int sel);
        if (sel == 1)
            return {2'b00, if6.reg_read_en, 2'b00, if6.reg_write_en, if6.bus_out_en,
                    if6.rsp_valid, if6.busy, if6.cmd_ready, if6.err};
        return {if8.reg_read_en, if8.reg_write_en, if8.bus_out_en,
                if8.rsp_valid, if8.busy, if8.cmd_ready, if8.err};
    endfunction

    function automatic logic [7:0] obs_rsp(input int sel);
        return (sel == 1) ? if6.rsp_data : if8.rsp_data;
    endfunction

    function automatic logic [7:0] obs_bus_out(input int sel);
        return (sel == 1) ? if6.bus_out : if8.bus_out;
    endfunction

    function automatic logic [7:0] env_val(input int sel, input int i);
        return (sel == 1) ? env6[i] : env8[i];
    endfunction

    task automatic chk_inv(input int sel);
        logic [20:0] s;
        logic [7:0]  rd, wr;
        logic        boe, ok;
        s   = obs_status(sel);
        rd  = s[20:13];
        wr  = s[12:5];
        boe = s[4];
        ok  = (($countones(rd) + (boe ? 1 : 0)) <= 1) && ($countones(wr) <= 1) &&
              ((wr == 8'h00) || (rd != 8'h00) || boe);
        chk($sformatf("invariant s%0d", sel), 32'(ok), 32'd1);
    endtask

    task automatic drive_cmd(input int sel, input logic v, input logic [1:0] op,
                             input logic [2:0] src, input logic [2:0] dst, input logic [7:0] imm);
        if8.cmd_valid = v && (sel == 0);
        if6.cmd_valid = v && (sel == 1);
        if8.cmd_op    = op_t'(op);
        if6.cmd_op    = op_t'(op);
        if8.cmd_src   = src;
        if6.cmd_src   = src;
        if8.cmd_dst   = dst;
        if6.cmd_dst   = dst;
        if8.cmd_imm   = imm;
        if6.cmd_imm   = imm;
    endtask

    // Runs one command from a ready cycle and checks every following cycle
    // against the expected timeline. rst_at>0 raises res after cycle rst_at.
    task automatic do_cmd(input int sel, input logic [1:0] op, input logic [2:0] src,
                          input logic [2:0] dst, input logic [7:0] imm,
                          input bit hold, input int rst_at);
        int         st, nr, last;
        bit         uses_src, uses_dst, legal, active, wrote, drv;
        logic [7:0] wv, e_rd, e_wr;
        logic       e_boe, e_rv, e_busy, e_err;
        st       = (sel == 1) ? 3 : 1;
        nr       = (sel == 1) ? 6 : 8;
        uses_src = (op == OP_MOV) || (op == OP_RD);
        uses_dst = (op == OP_MOV) || (op == OP_LDI);
        legal    = !((uses_src && int'(src) >= nr) || (uses_dst && int'(dst) >= nr));
        active   = legal && (op != OP_NOP);
        last     = active ? st + 3 : 2;
        if (rst_at > 0) last = rst_at + 2;
        wrote    = active && uses_dst && (rst_at == 0 || rst_at >= st + 1);
        wv       = (op == OP_LDI) ? imm : mdl[sel][src];
        drive_cmd(sel, 1'b1, op, src, dst, imm);
        @(posedge clk);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            e_rd = 8'h00; e_wr = 8'h00; e_boe = 1'b0; e_rv = 1'b0; e_busy = 1'b0; e_err = 1'b0;
            if (rst_at > 0 && k > rst_at) begin
                exp_rsp[0] = 8'h00;
                exp_rsp[1] = 8'h00;
            end else if (active) begin
                drv    = (k <= st + 1);
                e_rd   = (drv && uses_src) ? (8'h01 << src) : 8'h00;
                e_boe  = drv && (op == OP_LDI);
                e_wr   = (k == st + 1 && uses_dst) ? (8'h01 << dst) : 8'h00;
                e_rv   = (op == OP_RD) && (k == st + 2);
                e_busy = (k <= st + 2);
                if (e_rv) exp_rsp[sel] = mdl[sel][src];
            end else begin
                e_err = !legal && (k == 1);
            end
            chk($sformatf("status s%0d op%0d k%0d", sel, op, k), 32'(obs_status(sel)),
                32'({e_rd, e_wr, e_boe, e_rv, e_busy, !e_busy, e_err}));
            chk($sformatf("rsp_data s%0d k%0d", sel, k), 32'(obs_rsp(sel)), 32'(exp_rsp[sel]));
            if (e_boe) chk($sformatf("bus_out s%0d k%0d", sel, k), 32'(obs_bus_out(sel)), 32'(imm));
            chk_inv(sel);
            if (rst_at > 0 && k == rst_at) res = 1'b1;
            if (rst_at > 0 && k == rst_at + 1) res = 1'b0;
            if (k < last && hold && active && rst_at == 0)
                drive_cmd(sel, 1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
            else
                drive_cmd(sel, 1'b0, op, src, dst, imm);
        end
        if (wrote) mdl[sel][dst] = wv;
        for (int i = 0; i < nr; i++)
            chk($sformatf("reg s%0d r%0d", sel, i), 32'(env_val(sel, i)), 32'(mdl[sel][i]));
    endtask

    initial begin
        res     = 1'b1;
        tb_load = 1'b1;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++) init_val[s][i] = 8'($urandom_range(0, 255));
        init_val[0][0] = 8'h5A;
        init_val[0][2] = 8'hA5;
        drive_cmd(0, 1'b0, 2'd3, 3'd0, 3'd0, 8'h00);
        exp_rsp[0] = 8'h00;
        exp_rsp[1] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("reset status s%0d", s), 32'(obs_status(s)), 32'h0000_0002);
            chk($sformatf("reset bus_out s%0d", s), 32'(obs_bus_out(s)), 32'h0);
            chk($sformatf("reset rsp_data s%0d", s), 32'(obs_rsp(s)), 32'h0);
        end
        res     = 1'b0;
        tb_load = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 8; i++) mdl[s][i] = init_val[s][i];

        do_cmd(0, OP_MOV, 3'd2, 3'd5, 8'h00, 1'b0, 0);
        chk("mov reg5", 32'(env8[5]), 32'hA5);
        do_cmd(0, OP_LDI, 3'd0, 3'd7, 8'h3C, 1'b0, 0);
        do_cmd(0, OP_RD,  3'd0, 3'd0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk("rd hold", 32'(if8.rsp_data), 32'h5A);

        do_cmd(0, OP_MOV, 3'd1, 3'd3, 8'h00, 1'b1, 0);
        do_cmd(0, OP_MOV, 3'd6, 3'd0, 8'h00, 1'b1, 0);
        chk("b2b gap", 32'(acc_last[0] - acc_prev[0]), 32'd4);
        do_cmd(0, OP_MOV, 3'd4, 3'd4, 8'h00, 1'b0, 0);
        do_cmd(0, OP_NOP, 3'd1, 3'd2, 8'h77, 1'b0, 0);

        do_cmd(0, OP_MOV, 3'd5, 3'd1, 8'h00, 1'b0, 2);
        do_cmd(0, OP_LDI, 3'd0, 3'd2, 8'h99, 1'b0, 0);

        do_cmd(1, OP_MOV, 3'd1, 3'd6, 8'h00, 1'b0, 0);
        do_cmd(1, OP_RD,  3'd7, 3'd0, 8'h00, 1'b0, 0);
        do_cmd(1, OP_MOV, 3'd0, 3'd5, 8'h00, 1'b1, 0);
        do_cmd(1, OP_RD,  3'd5, 3'd0, 8'h00, 1'b0, 0);

        for (int n = 0; n < 30; n++)
            do_cmd(0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
        for (int n = 0; n < 20; n++)
            do_cmd(1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
